// File: rtl/game_pkg.sv
// Shared types and helpers for the game timing blocks.
// Contents: timer FSM state type, BCD digit limit, clamp and BCD-to-binary helpers.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } timer_state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

   function automatic logic [6:0] bcd_to_bin(input logic [3:0] t,
                                             input logic [3:0] o);
      return ({3'b000, t} * 7'd10) + {3'b000, o};
   endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with clamped load and decrement enable.
// Ports: clk, rst (async active-low), load_i/load_tens_i/load_ones_i,
//        dec_i, tens_o/ones_o (digits), zero_next_o (01 and decrementing).
module bcd_down_counter
   import game_pkg::*;
#(
   parameter logic [3:0] RST_TENS = 4'd6,
   parameter logic [3:0] RST_ONES = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [3:0] load_tens_i,
   input  logic [3:0] load_ones_i,
   input  logic       dec_i,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o,
   output logic       zero_next_o
);

   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       nonzero;

   assign nonzero = (tens_q != 4'd0) || (ones_q != 4'd0);

   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (load_i) begin
         tens_d = bcd_clamp(load_tens_i);
         ones_d = bcd_clamp(load_ones_i);
      end else if (dec_i && nonzero) begin
         if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
         end else begin
            ones_d = BCD_MAX;
            tens_d = tens_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tens_q <= RST_TENS;
         ones_q <= RST_ONES;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens_o      = tens_q;
   assign ones_o      = ones_q;
   assign zero_next_o = dec_i && (tens_q == 4'd0) && (ones_q == 4'd1);

endmodule

// File: rtl/countdown_timer.sv
// Game countdown timer: BCD seconds counting down on prescaler ticks.
// Ports: clk, rst (async active-low), tick, load/load_tens/load_ones,
//        start, pause; outputs tens, ones, running, warn, time_up, expired.
module countdown_timer
   import game_pkg::*;
#(
   parameter logic [3:0] DEFAULT_TENS = 4'd6,
   parameter logic [3:0] DEFAULT_ONES = 4'd0,
   parameter logic [6:0] WARN_SECS    = 7'd10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       running,
   output logic       warn,
   output logic       time_up,
   output logic       expired
);

   timer_state_t state_q, state_d;
   logic         expired_q, expired_d;
   logic         cnt_load;
   logic         cnt_dec;
   logic         zero_next;
   logic         digits_zero;
   logic         go;
   logic [6:0]   secs;

   // Load is honoured everywhere except while counting.
   assign cnt_load = load && (state_q != RUN);
   assign cnt_dec  = tick && (state_q == RUN);

   bcd_down_counter #(
      .RST_TENS (DEFAULT_TENS),
      .RST_ONES (DEFAULT_ONES)
   ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .load_i      (cnt_load),
      .load_tens_i (load_tens),
      .load_ones_i (load_ones),
      .dec_i       (cnt_dec),
      .tens_o      (tens),
      .ones_o      (ones),
      .zero_next_o (zero_next)
   );

   assign digits_zero = (tens == 4'd0) && (ones == 4'd0);
   // Pause dominates start; a same-cycle load takes priority over start.
   assign go = start && !pause && !load;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (go) state_d = digits_zero ? EXPIRED : RUN;
         end
         RUN: begin
            if (zero_next)  state_d = EXPIRED;
            else if (pause) state_d = PAUSE;
         end
         PAUSE: begin
            if (go) state_d = RUN;
         end
         EXPIRED: begin
            if (load) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      expired_d = (state_d == EXPIRED) && (state_q != EXPIRED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         expired_q <= expired_d;
      end
   end

   assign secs    = bcd_to_bin(tens, ones);
   assign running = (state_q == RUN);
   assign time_up = (state_q == EXPIRED);
   assign expired = expired_q;
   assign warn    = ((state_q == RUN) || (state_q == PAUSE)) &&
                    (secs != 7'd0) && (secs <= WARN_SECS);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: per-cycle expected snapshots
// queued with stimulus, compared against observed snapshots per scenario.
module tb_countdown_timer;

   typedef struct packed {
      logic [3:0] t;
      logic [3:0] o;
      logic       run;
      logic       wrn;
      logic       tup;
      logic       exp;
   } snap_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_tens = 4'd0;
   logic [3:0] load_ones = 4'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] tens, ones;
   logic       running, warn, time_up, expired;

   snap_t exp_q[$];
   snap_t obs_q[$];
   int checks = 0;
   int errors = 0;

   countdown_timer dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .load      (load),
      .load_tens (load_tens),
      .load_ones (load_ones),
      .start     (start),
      .pause     (pause),
      .tens      (tens),
      .ones      (ones),
      .running   (running),
      .warn      (warn),
      .time_up   (time_up),
      .expired   (expired)
   );

   always #5 clk = ~clk;

   function automatic snap_t mk(input logic [3:0] t, input logic [3:0] o,
                                input logic r, input logic w,
                                input logic tu, input logic ex);
      snap_t s;
      s = '{t: t, o: o, run: r, wrn: w, tup: tu, exp: ex};
      return s;
   endfunction

   task automatic snap_obs();
      obs_q.push_back(mk(tens, ones, running, warn, time_up, expired));
   endtask

   // One clock of stimulus; expectation queued with it.
   task automatic cyc(input logic tk, input logic ld, input logic [3:0] lt,
                      input logic [3:0] lo, input logic st, input logic ps,
                      input snap_t e);
      @(negedge clk);
      tick = tk; load = ld; load_tens = lt; load_ones = lo;
      start = st; pause = ps;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      snap_obs();
      tick = 0; load = 0; start = 0; pause = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(mk(6, 0, 0, 0, 0, 0));
      snap_obs();
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, mk(6, 0, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         snap_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_count();
      do_reset();
      cyc(0, 1, 1, 2, 0, 0, mk(1, 2, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, 0, mk(1, 2, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0, 0, mk(1, 2, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(1, 1, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(1, 0, 1, 1, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(0, 9, 1, 1, 0, 0));
      while (exp_q.size() > 0) begin
         snap_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL count: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_expire();
      do_reset();
      cyc(0, 1, 0, 2, 0, 0, mk(0, 2, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, 0, mk(0, 2, 1, 1, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(0, 1, 1, 1, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 1));
      cyc(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0));
      cyc(1, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 0));
      cyc(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 1, 0));
      cyc(0, 1, 3, 0, 0, 0, mk(3, 0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 0, 0, mk(3, 0, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         snap_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL expire: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_warn_pause();
      do_reset();
      cyc(0, 1, 1, 5, 0, 0, mk(1, 5, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, 0, mk(1, 5, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(1, 4, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(1, 3, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(1, 2, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(1, 1, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(1, 0, 1, 1, 0, 0));
      cyc(0, 0, 0, 0, 0, 1, mk(1, 0, 0, 1, 0, 0));
      for (int i = 0; i < 3; i++)
         cyc(1, 0, 0, 0, 0, 1, mk(1, 0, 0, 1, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0));
      cyc(0, 0, 0, 0, 1, 0, mk(1, 0, 1, 1, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(0, 9, 1, 1, 0, 0));
      while (exp_q.size() > 0) begin
         snap_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL warn_pause: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_clamp_zero();
      do_reset();
      cyc(0, 0, 0, 0, 1, 1, mk(6, 0, 0, 0, 0, 0));
      cyc(0, 1, 4'hF, 4'hC, 0, 0, mk(9, 9, 0, 0, 0, 0));
      cyc(0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 1));
      cyc(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0));
      while (exp_q.size() > 0) begin
         snap_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL clamp_zero: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_tick_pause();
      do_reset();
      cyc(0, 1, 2, 0, 0, 0, mk(2, 0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, 0, mk(2, 0, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 0, 1, mk(1, 9, 0, 0, 0, 0));
      cyc(0, 1, 4, 5, 0, 0, mk(4, 5, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, 1, mk(4, 5, 0, 0, 0, 0));
      cyc(1, 0, 0, 0, 1, 0, mk(4, 5, 1, 0, 0, 0));
      cyc(0, 1, 1, 1, 0, 0, mk(4, 5, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 1, 0, mk(4, 4, 1, 0, 0, 0));
      cyc(1, 0, 0, 0, 0, 0, mk(4, 3, 1, 0, 0, 0));
      while (exp_q.size() > 0) begin
         snap_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL tick_pause: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_reset_midrun();
      do_reset();
      cyc(0, 1, 3, 7, 0, 0, mk(3, 7, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, 0, mk(3, 7, 1, 0, 0, 0));
      #2;
      rst = 1'b0;
      #1;
      exp_q.push_back(mk(6, 0, 0, 0, 0, 0));
      snap_obs();
      rst = 1'b1;
      cyc(1, 0, 0, 0, 0, 0, mk(6, 0, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         snap_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_midrun: got %h want %h", o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_expire();
      test_warn_pause();
      test_clamp_zero();
      test_tick_pause();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
